// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and constants.
// Loader FSM states and frame geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/word_packer.sv
// word_packer: big-endian byte-to-word assembler.
// Emits one registered word_valid per four pushed bytes.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [1:0]  idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] acc;

  // shift bytes in MSB first; publish the word on the fourth byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      idx        <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (push) begin
        if (idx == LAST_IDX) begin
          word       <= {acc, din};
          word_valid <= 1'b1;
          idx        <= '0;
        end else begin
          acc <= {acc[15:0], din};
          idx <= idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to instruction memory.
// Holds the core until a frame loads with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  loader_state_t state, state_nx;

  logic [7:0]        len_hi;
  logic [15:0]       len;
  logic [15:0]       wcnt;
  logic [7:0]        chk;
  logic [ADDR_W-1:0] waddr;

  logic        accept;
  logic        clr;
  logic        push;
  logic        done_set;
  logic        last_byte;
  logic        too_big;
  logic [15:0] len_in;
  logic [1:0]  idx;

  assign in_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                    (state == S_DATA)   || (state == S_CHK);
  assign busy      = in_ready;
  assign error     = (state == S_ERR);
  assign accept    = in_valid && in_ready;
  assign last_byte = (idx == LAST_IDX);
  assign len_in    = {len_hi, in_byte};
  assign too_big   = {16'd0, len_in} > (32'd1 << ADDR_W);
  assign mem_waddr = waddr;

  word_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clr),
    .push       (push),
    .din        (in_byte),
    .idx        (idx),
    .word_valid (mem_we),
    .word       (mem_wdata)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    push     = 1'b0;
    done_set = 1'b0;
    unique case (state)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_nx = S_LEN_HI;
          clr      = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (accept) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if (too_big)             state_nx = S_ERR;
          else if (len_in == '0)   state_nx = S_CHK;
          else                     state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          push = 1'b1;
          if (last_byte && (wcnt + 16'd1 == len))
            state_nx = S_CHK;
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_byte == chk) begin
            state_nx = S_IDLE;
            done_set = 1'b1;
          end else begin
            state_nx = S_ERR;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // length capture, word count, checksum, address and hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_hi   <= '0;
      len      <= '0;
      wcnt     <= '0;
      chk      <= '0;
      waddr    <= '0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      done <= done_set;
      if (clr) begin
        wcnt     <= '0;
        chk      <= '0;
        waddr    <= '0;
        cpu_hold <= 1'b1;
      end else begin
        if (done_set) cpu_hold <= 1'b0;
        if (state == S_LEN_HI && accept) len_hi <= in_byte;
        if (state == S_LEN_LO && accept) len <= len_in;
        if (push) chk <= chk ^ in_byte;
        if (push && last_byte) wcnt <= wcnt + 16'd1;
        if (mem_we) waddr <= waddr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the single-cycle MIPS core. It writes into instruction memory, which the core otherwise only reads. It receives a framed byte stream over a valid/ready handshake, packs bytes big-endian into 32-bit words, and writes them to consecutive word addresses of the instruction memory write port. It holds the core (`cpu_hold`) from reset until a frame has been loaded and its checksum verified.

## Interface
Parameters:
- `ADDR_W`, default 10: instruction-memory word-address width (1024 words).

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle pulse; arms a new load.
- `in_valid`  in  1  byte source has data.
- `in_byte`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write strobe.
- `mem_waddr`  out  ADDR_W  word address (byte address >> 2).
- `mem_wdata`  out  32  word to write.
- `cpu_hold`  out  1  core PC/regfile held while 1.
- `busy`  out  1  frame in progress.
- `done`  out  1  one-cycle pulse on successful load.
- `error`  out  1  sticky load failure.

## Operation
- Frame: `LEN_HI`, `LEN_LO` (word count N, 16-bit, big-endian), then 4·N payload bytes (MSB first per word), then one checksum byte equal to the XOR of all payload bytes (length bytes excluded).
- A byte is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in `S_LEN_HI`, `S_LEN_LO`, `S_DATA` and `S_CHK`; 0 in `S_IDLE` and `S_ERR`.
- FSM states: `S_IDLE`, `S_LEN_HI`, `S_LEN_LO`, `S_DATA`, `S_CHK`, `S_ERR`.
  - `S_IDLE` → `S_LEN_HI` on `start`. On this transition: clear `error`, checksum, byte index and word address.
  - `S_ERR` → `S_LEN_HI` on `start`, with the same clears.
  - `S_LEN_HI` → `S_LEN_LO` on accept.
  - `S_LEN_LO` → on accept:
    - `S_ERR` if N > 2^ADDR_W;
    - `S_CHK` if N = 0;
    - `S_DATA` otherwise.
  - `S_DATA`: 2-bit byte index. Every accepted byte XORs into the checksum. When byte 3 is accepted, the word completes. If completed words reach N, go to `S_CHK`.
  - `S_CHK` → on accept:
    - `S_IDLE` with `done` pulsed if the byte equals the checksum;
    - `S_ERR` otherwise.
- `start` while `busy` is ignored.
- `cpu_hold` = 1 from reset. It drops in the cycle `done` pulses. It rises again on any `start`. It stays 1 in `S_ERR`.
- `busy` = 1 in every state except `S_IDLE` and `S_ERR`.
- Reset values: `in_ready`=0, `mem_we`=0, `mem_waddr`=0, `mem_wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `error`=0, state `S_IDLE`.
- Reset during a frame aborts it. Words already written stay in memory.

## Timing
- `mem_we`, `mem_waddr`, `mem_wdata` are registered. The write strobe is high for exactly the one cycle after byte 3 of a word is accepted.
- `mem_waddr` for word k = k. The address increments after each write.
- Maximum throughput is one byte per cycle. Gaps in `in_valid` stall the loader with no state loss.
- `done` is high in the cycle after the checksum byte is accepted. The last `mem_we` of the frame precedes `done` by at least one cycle.
- `error` rises in the cycle after the offending byte is accepted and holds until `start`.

## Structure
- Package `imem_loader_pkg`: state enum `loader_state_t`, `HDR_BYTES` = 2, `BYTES_PER_WORD` = 4.
- Sub-module `word_packer`: shifts bytes into a 32-bit register, keeps the byte index, and emits a one-cycle `word_valid`. The top level owns the FSM, the length/word counters and the checksum.

## Test plan
- Good frame, stream 00 02 8C 01 00 00 8C 02 00 04 07 → writes (0, 8C010000) and (1, 8C020004). `done` pulses once; `cpu_hold` = 0; `error` = 0.
- Same frame with checksum 00 → both writes occur, then `error` = 1, `cpu_hold` = 1, no `done`. A new `start` plus the good frame recovers.
- Length 04 01 with `ADDR_W`=10 → `error` after `LEN_LO`, zero `mem_we`, `in_ready` = 0.
- Empty frame 00 00 00 → `done` with zero writes; `cpu_hold` drops.
- Good frame with random `in_valid` gaps, plus a `start` pulse mid-frame → identical writes and `done` timing relative to the last accepted byte; the `start` has no effect.
- `rst_n` low after 5 payload bytes → all outputs at reset values immediately. Word 0 (written before reset) remains in memory. A following full frame loads correctly.
